para_encoder: RTL and testbench
===============================

// Module: para_encoder
// PURPOSE
//  Inverse of the parameter-code decoder. Receives a displayed parameter code as two 4-bit nibbles over a valid/ready stream:
//   - the letter nibble first, 0xA-0xE;
//   - then the suffix nibble, 0x1, 0x2 or 0xF.
//  Recovers the 4-bit parameter index and presents it on a valid/ready output. Malformed or stalled codes are flagged and counted.
//  Sits between the front-panel/serial parameter entry path and the pulse-generator parameter registers.
// PARAMETERS
//  TIMEOUT_CYC  1000  max cycles allowed between letter acceptance and suffix acceptance
//  ERR_W        8     width of saturating error counter
// PORTS
//  CLOCK      in   1      single clock; all logic rising-edge
//  RESET_N    in   1      asynchronous, active-low reset
//  NIB_IN     in   4      code nibble (letter or suffix)
//  NIB_VALID  in   1      NIB_IN valid
//  NIB_READY  out  1      encoder accepts NIB_IN; nibble consumed on edge with VALID&READY
//  PARA_OUT   out  4      decoded parameter index
//  PARA_VALID out  1      PARA_OUT valid; held until accepted
//  PARA_READY in   1      consumer accepts PARA_OUT
//  PARA_ERR   out  1      one-cycle pulse: bad letter, bad pair, or timeout
//  ERR_CNT    out  ERR_W  saturating count of PARA_ERR pulses
// BEHAVIOUR
//  Code table {letter,suffix} -> index:
//   A1->0   A2->1   BF->2   CF->3   DF->4   B1->5
//   C1->6   B2->7   D1->8   EF->9   D2->10  C2->11
//   No code maps to 12-15; any other pair is invalid.
//  Reset values: NIB_READY=0, PARA_OUT=0, PARA_VALID=0, PARA_ERR=0, ERR_CNT=0, state=S_LETTER, timeout counter=0.
//  All outputs are registered.
//  NIB_READY:
//   - next value is 1 iff next state is S_LETTER or S_SUFFIX;
//   - first goes high on the first edge after RESET_N release.
//  S_LETTER (accept edge):
//   - NIB_IN in 0xA-0xE: latch letter, go to S_SUFFIX, clear timeout counter;
//   - otherwise: PARA_ERR=1 next cycle, stay in S_LETTER.
//  S_SUFFIX (accept edge):
//   - pair in table: PARA_OUT<=index, PARA_VALID<=1, go to S_OUT;
//   - pair not in table: PARA_ERR pulse, go to S_LETTER;
//   - no accept: timeout counter +1.
//  Timeout:
//   - fires on the TIMEOUT_CYC-th edge after letter acceptance with no suffix accepted;
//   - result: PARA_ERR pulse, go to S_LETTER, discard the letter;
//   - if NIB_VALID is high on that same edge, the suffix is accepted and no timeout occurs.
//  S_OUT:
//   - NIB_READY=0; PARA_OUT and PARA_VALID stable until PARA_VALID&PARA_READY;
//   - on that edge: PARA_VALID<=0, go to S_LETTER;
//   - no timeout applies in S_OUT.
//  Latency: suffix accept edge k -> PARA_VALID high after edge k.
//   - PARA_READY=1 at that point: VALID low after edge k+1, NIB_READY high after edge k+1.
//   - Sustained throughput: 1 index per 3 cycles.
//  ERR_CNT:
//   - +1 per PARA_ERR pulse;
//   - saturates at 2^ERR_W-1 and never wraps.
//  PARA_OUT holds its last value while PARA_VALID=0.
//  RESET_N low mid-operation: immediate return to reset values; a partial code or pending output is dropped.
// STRUCTURE
//  Package para_code_pkg, shared with the decoder:
//   - letter constants L_N=0xA, L_B=0xB, L_C=0xC, L_D=0xD, L_E=0xE;
//   - suffix constants S_1=0x1, S_2=0x2, S_NONE=0xF;
//   - index constants P_N1..P_C2 (0-11);
//   - state encoding S_LETTER/S_SUFFIX/S_OUT.
//  Sub-module para_code_lookup:
//   - combinational {letter,suffix} -> {hit, index[3:0]};
//   - top holds FSM, timeout counter, output registers, error counter.
// TESTING
//  - Reset then stream every table pair with PARA_READY=1:
//    all 12 pairs in order -> PARA_OUT 0..11 in order, PARA_ERR never pulses.
//  - Nibbles 0xC,0x2 with PARA_READY=0 for 5 cycles:
//    PARA_OUT=11 and PARA_VALID=1 held stable, NIB_READY=0 throughout; released on READY.
//  - Letter 0x3:
//    one PARA_ERR pulse, ERR_CNT 0->1, stays in S_LETTER.
//  - Pair 0xE,0x1:
//    PARA_ERR pulse, no PARA_VALID.
//    Next pair 0xE,0xF -> PARA_OUT=9.
//  - TIMEOUT_CYC=4, letter 0xB then idle:
//    PARA_ERR on the 4th edge, back to S_LETTER.
//    Repeat with suffix 0x1 arriving on exactly the 4th edge -> PARA_OUT=5, no error.
//  - ERR_W=2, 5 bad letters:
//    ERR_CNT=3 (saturated).
//    Assert RESET_N=0 mid-suffix -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/para_code_pkg.sv
// para_code_pkg: parameter-code letters, suffixes, indices and encoder states
package para_code_pkg;
  localparam logic [3:0] L_N = 4'hA;
  localparam logic [3:0] L_B = 4'hB;
  localparam logic [3:0] L_C = 4'hC;
  localparam logic [3:0] L_D = 4'hD;
  localparam logic [3:0] L_E = 4'hE;
  localparam logic [3:0] S_1 = 4'h1;
  localparam logic [3:0] S_2 = 4'h2;
  localparam logic [3:0] S_NONE = 4'hF;
  localparam logic [3:0] P_N1 = 4'd0;
  localparam logic [3:0] P_N2 = 4'd1;
  localparam logic [3:0] P_B = 4'd2;
  localparam logic [3:0] P_C = 4'd3;
  localparam logic [3:0] P_D = 4'd4;
  localparam logic [3:0] P_B1 = 4'd5;
  localparam logic [3:0] P_C1 = 4'd6;
  localparam logic [3:0] P_B2 = 4'd7;
  localparam logic [3:0] P_D1 = 4'd8;
  localparam logic [3:0] P_E = 4'd9;
  localparam logic [3:0] P_D2 = 4'd10;
  localparam logic [3:0] P_C2 = 4'd11;
  typedef enum logic [1:0] {S_LETTER, S_SUFFIX, S_OUT} state_t;
endpackage

// File: rtl/para_encoder_if.sv
// para_encoder_if: nibble input stream, index output stream and error status
interface para_encoder_if #(parameter int ERR_W = 8);
  logic [3:0] nib_in;
  logic nib_valid;
  logic nib_ready;
  logic [3:0] para_out;
  logic para_valid;
  logic para_ready;
  logic para_err;
  logic [ERR_W-1:0] err_cnt;
  modport master (output nib_in, nib_valid, para_ready, input nib_ready, para_out, para_valid, para_err, err_cnt);
  modport slave (input nib_in, nib_valid, para_ready, output nib_ready, para_out, para_valid, para_err, err_cnt);
endinterface

// File: rtl/para_code_lookup.sv
// para_code_lookup: combinational {letter,suffix} to parameter index table
module para_code_lookup
  import para_code_pkg::*;
(
  input  logic [3:0] letter,
  input  logic [3:0] suffix,
  output logic       hit,
  output logic [3:0] idx
);
  // unlisted pairs miss and report index 0
  always_comb begin
    hit = 1'b1;
    idx = '0;
    case ({letter, suffix})
      {L_N, S_1}:    idx = P_N1;
      {L_N, S_2}:    idx = P_N2;
      {L_B, S_NONE}: idx = P_B;
      {L_C, S_NONE}: idx = P_C;
      {L_D, S_NONE}: idx = P_D;
      {L_B, S_1}:    idx = P_B1;
      {L_C, S_1}:    idx = P_C1;
      {L_B, S_2}:    idx = P_B2;
      {L_D, S_1}:    idx = P_D1;
      {L_E, S_NONE}: idx = P_E;
      {L_D, S_2}:    idx = P_D2;
      {L_C, S_2}:    idx = P_C2;
      default:       hit = 1'b0;
    endcase
  end
endmodule

// File: rtl/para_encoder.sv
// para_encoder: two-nibble parameter code to index, with error flagging and counting
module para_encoder
  import para_code_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000,
  parameter int ERR_W = 8
) (
  input logic clk,
  input logic rst_n,
  para_encoder_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_t state, nxt;
  logic [3:0] letter_q, idx, para_out;
  logic [TW-1:0] tcnt;
  logic [ERR_W-1:0] err_cnt;
  logic hit, acc, letter_ok, tmo, err_d, load, nib_ready, para_valid, para_err;
  para_code_lookup u_lookup (.letter(letter_q), .suffix(bus.nib_in), .hit(hit), .idx(idx));
  assign acc = bus.nib_valid & nib_ready;
  assign letter_ok = bus.nib_in >= L_N && bus.nib_in <= L_E;
  assign tmo = tcnt == TW'(TIMEOUT_CYC - 1);
  assign bus.nib_ready = nib_ready;
  assign bus.para_out = para_out;
  assign bus.para_valid = para_valid;
  assign bus.para_err = para_err;
  assign bus.err_cnt = err_cnt;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_LETTER;
    else state <= nxt;
  // next state; a suffix accepted on the timeout edge wins over the timeout
  always_comb begin
    nxt = state;
    case (state)
      S_LETTER: nxt = acc && letter_ok ? S_SUFFIX : S_LETTER;
      S_SUFFIX: nxt = acc ? (hit ? S_OUT : S_LETTER) : (tmo ? S_LETTER : S_SUFFIX);
      default:  nxt = para_valid && bus.para_ready ? S_LETTER : S_OUT;
    endcase
  end
  // error and load decisions for the output registers
  always_comb begin
    err_d = (state == S_LETTER && acc && !letter_ok) || (state == S_SUFFIX && (acc ? !hit : tmo));
    load = state == S_SUFFIX && acc && hit;
  end
  // registered outputs, letter latch, timeout and saturating error counters
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      nib_ready <= 1'b0;
      para_out <= '0;
      para_valid <= 1'b0;
      para_err <= 1'b0;
      err_cnt <= '0;
      letter_q <= '0;
      tcnt <= '0;
    end else begin
      nib_ready <= nxt != S_OUT;
      para_valid <= nxt == S_OUT;
      para_err <= err_d;
      if (load) para_out <= idx;
      if (err_d && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      if (state == S_LETTER && acc && letter_ok) letter_q <= bus.nib_in;
      tcnt <= state == S_LETTER ? '0 : (state == S_SUFFIX && !acc ? tcnt + 1'b1 : tcnt);
    end
endmodule

// File: tb/tb_para_encoder.sv
// tb_para_encoder: directed checks of the parameter-code encoder
module tb_para_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  int err_seen = 0;
  para_encoder_if #(.ERR_W(2)) bus ();
  para_encoder #(.TIMEOUT_CYC(4), .ERR_W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (rst_n && bus.para_err) err_seen++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [3:0] n);
    int t = 0;
    @(negedge clk);
    bus.nib_in = n;
    bus.nib_valid = 1'b1;
    while (!bus.nib_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t == 20) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1 bus.nib_valid = 1'b0;
  endtask

  logic [3:0] lt [12] = '{4'hA, 4'hA, 4'hB, 4'hC, 4'hD, 4'hB, 4'hC, 4'hB, 4'hD, 4'hE, 4'hD, 4'hC};
  logic [3:0] sf [12] = '{4'h1, 4'h2, 4'hF, 4'hF, 4'hF, 4'h1, 4'h1, 4'h2, 4'h1, 4'hF, 4'h2, 4'h2};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.nib_in = '0;
    bus.nib_valid = 1'b0;
    bus.para_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_nib_ready", bus.nib_ready, 0);
    chk("rst_para_out", bus.para_out, 0);
    chk("rst_para_valid", bus.para_valid, 0);
    chk("rst_para_err", bus.para_err, 0);
    chk("rst_err_cnt", bus.err_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", bus.nib_ready, 1);
    for (int i = 0; i < 12; i++) begin
      send(lt[i]);
      send(sf[i]);
      @(negedge clk);
      chk($sformatf("stream_valid_%0d", i), bus.para_valid, 1);
      chk($sformatf("stream_out_%0d", i), bus.para_out, i);
    end
    @(negedge clk);
    chk("stream_no_err", err_seen, 0);
    bus.para_ready = 1'b0;
    send(4'hC);
    send(4'h2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall_valid_%0d", i), bus.para_valid, 1);
      chk($sformatf("stall_out_%0d", i), bus.para_out, 11);
      chk($sformatf("stall_nib_ready_%0d", i), bus.nib_ready, 0);
    end
    bus.para_ready = 1'b1;
    @(negedge clk);
    chk("release_valid", bus.para_valid, 0);
    chk("release_nib_ready", bus.nib_ready, 1);
    send(4'h3);
    @(negedge clk);
    chk("bad_letter_err", bus.para_err, 1);
    @(negedge clk);
    chk("bad_letter_pulse_end", bus.para_err, 0);
    chk("bad_letter_cnt", bus.err_cnt, 1);
    chk("bad_letter_ready", bus.nib_ready, 1);
    send(4'hE);
    send(4'h1);
    @(negedge clk);
    chk("bad_pair_err", bus.para_err, 1);
    chk("bad_pair_no_valid", bus.para_valid, 0);
    send(4'hE);
    send(4'hF);
    @(negedge clk);
    chk("ef_valid", bus.para_valid, 1);
    chk("ef_out", bus.para_out, 9);
    send(4'hB);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("tmo_quiet_%0d", i), bus.para_err, 0);
    end
    @(negedge clk);
    chk("tmo_err", bus.para_err, 1);
    chk("tmo_ready", bus.nib_ready, 1);
    @(negedge clk);
    chk("tmo_cnt", bus.err_cnt, 3);
    send(4'hB);
    repeat (3) @(negedge clk);
    send(4'h1);
    @(negedge clk);
    chk("edge_sfx_valid", bus.para_valid, 1);
    chk("edge_sfx_out", bus.para_out, 5);
    chk("edge_sfx_no_err", bus.para_err, 0);
    send(4'hA);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_nib_ready", bus.nib_ready, 0);
    chk("async_para_out", bus.para_out, 0);
    chk("async_para_valid", bus.para_valid, 0);
    chk("async_err_cnt", bus.err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      send(4'h5);
      repeat (2) @(negedge clk);
      chk($sformatf("sat_cnt_%0d", i), bus.err_cnt, i > 3 ? 3 : i);
    end
    send(4'hA);
    send(4'h2);
    @(negedge clk);
    chk("post_rst_valid", bus.para_valid, 1);
    chk("post_rst_out", bus.para_out, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
